// File: rtl/uart_tx_fifo_sim.sv
// Memory-mapped UART transmit peripheral: buffers CPU byte stores in a FIFO and drains them as paced byte strobes.
// Optional macro UART_SIM_PRINT_EN echoes each drained byte to the simulator console.
module uart_tx_fifo_sim #(
  parameter logic [31:0] BASE_ADDR    = 32'h6000_0000,
  parameter int          DEPTH        = 16,
  parameter int          DRAIN_CYCLES = 8
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic [3:0]  Write_strb,
  output logic        Mem_Req_Ack,
  output logic [31:0] Read_data,
  output logic        Read_data_Valid,
  input  logic        Read_data_Ready,
  output logic        tx_valid,
  output logic [7:0]  tx_byte,
  output logic        empty_fifo,
  output logic        full_fifo
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_RELOAD = DW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] FULL_COUNT   = CW'(DEPTH);

  typedef enum logic {IDLE, RESP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic [DW-1:0] drain_cnt;

  logic          hit;
  logic [1:0]    offset;
  logic          write_req;
  logic          read_req;
  logic          push;
  logic          pop;
  logic [4:0]    count5;
  logic [31:0]   read_value;
  logic          unused_bits;

  assign unused_bits = ^{Address[1:0], Write_data[31:8], Write_strb[3:1]};

  // Writes win over reads; a full FIFO stalls TXDATA stores using the registered flag only.
  always_comb begin
    hit         = (Address[31:4] == BASE_ADDR[31:4]);
    offset      = Address[3:2];
    write_req   = MemWrite && hit && (state == IDLE);
    read_req    = MemRead && !MemWrite && hit && (state == IDLE);
    Mem_Req_Ack = sys_reset_n &&
                  ((write_req && !((offset == 2'd0) && full_fifo)) || read_req);
    push        = write_req && (offset == 2'd0) && !full_fifo && Write_strb[0];
    pop         = (count != '0) && (drain_cnt == '0);
    count5      = 5'(count);
    read_value  = (offset == 2'd1) ? {24'b0, count5, 1'b0, full_fifo, empty_fifo} : 32'b0;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= Write_data[7:0];
  end

  // The drain timer idles at its reload value while empty, so the first pop lands DRAIN_CYCLES after the first push.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drain_cnt  <= '0;
      empty_fifo <= 1'b1;
      full_fifo  <= 1'b0;
      tx_valid   <= 1'b0;
      tx_byte    <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count      <= count_next;
      empty_fifo <= (count_next == '0);
      full_fifo  <= (count_next == FULL_COUNT);
      tx_valid   <= pop;
      if (pop) tx_byte <= mem[rd_ptr];
      if ((count == '0) || pop) drain_cnt <= DRAIN_RELOAD;
      else                      drain_cnt <= drain_cnt - DW'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state           <= IDLE;
      Read_data       <= 32'b0;
      Read_data_Valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read_req) begin
            Read_data       <= read_value;
            Read_data_Valid <= 1'b1;
            state           <= RESP;
          end
        end
        RESP: begin
          if (Read_data_Ready) begin
            Read_data_Valid <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_SIM_PRINT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_reset_n && pop) $write("%c", mem[rd_ptr]);
  end
`else
`endif

endmodule
